alu_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 80 ++++++++
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer states and default operand width for the ALU
// sequencer and its iterative multiply/divide engine.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_SHR = 5'b00101;
   localparam logic [4:0] OP_SHL = 5'b00110;
   localparam logic [4:0] OP_ROR = 5'b00111;
   localparam logic [4:0] OP_ROL = 5'b01000;
   localparam logic [4:0] OP_AND = 5'b01001;
   localparam logic [4:0] OP_OR  = 5'b01010;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   localparam logic [4:0] OP_NEG = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   function automatic logic is_iter_op(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-step engine on unsigned magnitudes: shift-add multiply or
// restoring divide, sharing one WIDTH+1 accumulator and one shift register.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             init,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH:0]   a_mag,
   input  logic [WIDTH:0]   b_mag,
   output logic [WIDTH-1:0] hi_mag,
   output logic [WIDTH-1:0] lo_mag
);

   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic             div_q, div_d;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   rem_sh_s;

   // Load on init, otherwise advance one multiply or divide step when enabled.
   always_comb begin
      acc_d    = acc_q;
      dvs_d    = dvs_q;
      mq_d     = mq_q;
      div_d    = div_q;
      sum_s    = acc_q + (mq_q[0] ? dvs_q : {(WIDTH+1){1'b0}});
      rem_sh_s = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      if (init) begin
         acc_d = {(WIDTH+1){1'b0}};
         div_d = div_mode;
         if (div_mode) begin
            mq_d  = a_mag[WIDTH-1:0];
            dvs_d = b_mag;
         end else begin
            mq_d  = b_mag[WIDTH-1:0];
            dvs_d = a_mag;
         end
      end else if (step) begin
         if (div_q) begin
            if (rem_sh_s >= dvs_q) begin
               acc_d = rem_sh_s - dvs_q;
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh_s;
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = {1'b0, sum_s[WIDTH:1]};
            mq_d  = {sum_s[0], mq_q[WIDTH-1:1]};
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Engine state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= {(WIDTH+1){1'b0}};
         dvs_q <= {(WIDTH+1){1'b0}};
         mq_q  <= {WIDTH{1'b0}};
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         dvs_q <= dvs_d;
         mq_q  <= mq_d;
         div_q <= div_d;
      end
   end

   assign hi_mag = acc_q[WIDTH-1:0];
   assign lo_mag = mq_q;

endmodule

// File: rtl/alu_sequencer.sv
// ALU controller: start/busy/done handshake, single-cycle ops, and sign fixup
// around the iterative multiply/divide engine; results held in ZHI/ZLO.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] Ra,
   input  logic [WIDTH-1:0] Rb,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             illegal_op,
   output logic [WIDTH-1:0] ZHI,
   output logic [WIDTH-1:0] ZLO
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
   localparam logic [CW:0]   WIDTH_V = (CW+1)'(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [4:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] zhi_q, zhi_d, zlo_q, zlo_d;
   logic             dbz_q, dbz_d, ill_q, ill_d, busy_q, busy_d, done_q, done_d;

   logic             eng_init_s, eng_step_s;
   logic [WIDTH:0]   a_ext_s, b_ext_s, a_mag_s, b_mag_s;
   logic [WIDTH-1:0] eng_hi_s, eng_lo_s;
   logic [2*WIDTH-1:0] prod_s, mul_fix_s;
   logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
   logic             sign_diff_s;
   logic [CW-1:0]    sh_s;
   logic [CW:0]      inv_sh_s;
   logic [WIDTH-1:0] simple_lo_s;
   logic             illegal_s;

   // Sign-extending first keeps the most negative operand's magnitude exact.
   assign a_ext_s = {Ra[WIDTH-1], Ra};
   assign b_ext_s = {Rb[WIDTH-1], Rb};
   assign a_mag_s = Ra[WIDTH-1] ? -a_ext_s : a_ext_s;
   assign b_mag_s = Rb[WIDTH-1] ? -b_ext_s : b_ext_s;

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clock    (clock),
      .reset    (reset),
      .init     (eng_init_s),
      .step     (eng_step_s),
      .div_mode (op == OP_DIV),
      .a_mag    (a_mag_s),
      .b_mag    (b_mag_s),
      .hi_mag   (eng_hi_s),
      .lo_mag   (eng_lo_s)
   );

   assign sign_diff_s = a_q[WIDTH-1] ^ b_q[WIDTH-1];
   assign prod_s      = {eng_hi_s, eng_lo_s};
   assign mul_fix_s   = sign_diff_s ? -prod_s : prod_s;
   assign quo_fix_s   = sign_diff_s ? -eng_lo_s : eng_lo_s;
   assign rem_fix_s   = a_q[WIDTH-1] ? -eng_hi_s : eng_hi_s;
   assign sh_s        = b_q[CW-1:0];
   assign inv_sh_s    = WIDTH_V - {1'b0, sh_s};

   // Single-cycle result for the latched opcode; unknown opcodes give zero.
   always_comb begin
      simple_lo_s = {WIDTH{1'b0}};
      illegal_s   = 1'b0;
      case (op_q)
         OP_ADD:  simple_lo_s = a_q + b_q;
         OP_SUB:  simple_lo_s = a_q - b_q;
         OP_SHR:  simple_lo_s = a_q >> sh_s;
         OP_SHL:  simple_lo_s = a_q << sh_s;
         OP_ROR:  simple_lo_s = (a_q >> sh_s) | (a_q << inv_sh_s);
         OP_ROL:  simple_lo_s = (a_q << sh_s) | (a_q >> inv_sh_s);
         OP_AND:  simple_lo_s = a_q & b_q;
         OP_OR:   simple_lo_s = a_q | b_q;
         OP_NEG:  simple_lo_s = -b_q;
         OP_NOT:  simple_lo_s = ~b_q;
         default: illegal_s   = 1'b1;
      endcase
   end

   // Sequencer next state, operand latching and result write-back.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      zhi_d      = zhi_q;
      zlo_d      = zlo_q;
      dbz_d      = dbz_q;
      ill_d      = ill_q;
      eng_init_s = 1'b0;
      eng_step_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_EXEC;
               op_d       = op;
               a_d        = Ra;
               b_d        = Rb;
               dbz_d      = 1'b0;
               ill_d      = 1'b0;
               cnt_d      = {CW{1'b0}};
               eng_init_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            if (is_iter_op(op_q)) begin
               if ((op_q == OP_DIV) && (b_q == {WIDTH{1'b0}})) begin
                  zhi_d   = a_q;
                  zlo_d   = {WIDTH{1'b1}};
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  eng_step_s = 1'b1;
                  cnt_d      = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  if (cnt_q == LAST) begin
                     state_d = S_FIXUP;
                     cnt_d   = {CW{1'b0}};
                  end else begin
                     state_d = S_EXEC;
                  end
               end
            end else begin
               zhi_d   = {WIDTH{1'b0}};
               zlo_d   = simple_lo_s;
               ill_d   = illegal_s;
               state_d = S_DONE;
            end
         end
         S_FIXUP: begin
            if (op_q == OP_DIV) begin
               zhi_d = rem_fix_s;
               zlo_d = quo_fix_s;
            end else begin
               {zhi_d, zlo_d} = mul_fix_s;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         op_q    <= 5'd0;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         zhi_q   <= {WIDTH{1'b0}};
         zlo_q   <= {WIDTH{1'b0}};
         dbz_q   <= 1'b0;
         ill_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         zhi_q   <= zhi_d;
         zlo_q   <= zlo_d;
         dbz_q   <= dbz_d;
         ill_q   <= ill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign illegal_op  = ill_q;
   assign ZHI         = zhi_q;
   assign ZLO         = zlo_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table of vectors plus modelled random
// operations feed a scoreboard checked on every done pulse, then corner sequences.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset, start;
   logic [4:0]   op;
   logic [W-1:0] Ra, Rb;
   logic         busy, done, div_by_zero, illegal_op;
   logic [W-1:0] ZHI, ZLO;

   alu_sequencer #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .Ra(Ra), .Rb(Rb),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
      .ZHI(ZHI), .ZLO(ZLO)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dbz, ill;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
      logic        dbz, ill;
      int          acc_cyc, lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl [17];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Independent reference: SV signed arithmetic on 64-bit integers.
   function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sbv, p;
      int     s;
      e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_cyc = 0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      s   = int'(b[4:0]);
      case (o)
         OP_ADD: e.lo = a + b;
         OP_SUB: e.lo = a - b;
         OP_SHR: e.lo = a >> s;
         OP_SHL: e.lo = a << s;
         OP_ROR: e.lo = (a >> s) | (a << (32 - s));
         OP_ROL: e.lo = (a << s) | (a >> (32 - s));
         OP_AND: e.lo = a & b;
         OP_OR:  e.lo = a | b;
         OP_NEG: e.lo = 32'd0 - b;
         OP_NOT: e.lo = ~b;
         OP_MUL: begin
            p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33;
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
            end else begin
               p = sa / sbv; e.lo = p[31:0];
               p = sa % sbv; e.hi = p[31:0];
               e.lat = 33;
            end
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Scoreboard check on every done pulse.
   always @(posedge clock) begin
      #1;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("zhi", 64'(ZHI), 64'(mon_e.hi));
            chk("zlo", 64'(ZLO), 64'(mon_e.lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
            chk("illegal_op", 64'(illegal_op), 64'(mon_e.ill));
            chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
         end
      end
   end

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clock);
         k++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
      @(negedge clock);
      start = 1'b1; op = o; Ra = a; Rb = b;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0; op = 5'($urandom); Ra = $urandom; Rb = $urandom;
      drain();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   c0;
      logic [4:0] ops [12];

      tbl[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
      tbl[1]  = '{OP_ROL, 32'h8000_0001, 32'h0000_0004, 32'h0000_0000, 32'h0000_0018, 1'b0, 1'b0, 1};
      tbl[2]  = '{OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 33};
      tbl[3]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 33};
      tbl[4]  = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 33};
      tbl[5]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 33};
      tbl[6]  = '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1'b0, 1};
      tbl[7]  = '{5'b11111, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
      tbl[8]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      tbl[9]  = '{OP_SHR, 32'h8000_0000, 32'h0000_003F, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1};
      tbl[10] = '{OP_ROR, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
      tbl[11] = '{OP_NEG, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
      tbl[12] = '{OP_NOT, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_0000, 32'hF0F0_F0F0, 1'b0, 1'b0, 1};
      tbl[13] = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 33};
      tbl[14] = '{OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 33};
      tbl[15] = '{OP_SHL, 32'h0000_0001, 32'h0000_0023, 32'h0000_0000, 32'h0000_0008, 1'b0, 1'b0, 1};
      tbl[16] = '{OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0000, 32'h0000_F000, 1'b0, 1'b0, 1};

      ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
              OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT};

      reset = 1'b1; start = 1'b0; op = 5'd0; Ra = 32'd0; Rb = 32'd0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      chk("rst_ill", 64'(illegal_op), 64'd0);
      chk("rst_zhi", 64'(ZHI), 64'd0);
      chk("rst_zlo", 64'(ZLO), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz; e.ill = tbl[i].ill;
         e.lat = tbl[i].lat; e.acc_cyc = 0;
         issue(tbl[i].op, tbl[i].a, tbl[i].b, e);
      end

      // Flags and result persist after done until the next accepted start.
      issue(OP_DIV, 32'd5, 32'd0, model(OP_DIV, 32'd5, 32'd0));
      repeat (3) @(negedge clock);
      chk("dbz_hold", 64'(div_by_zero), 64'd1);
      chk("zhi_hold", 64'(ZHI), 64'd5);
      chk("idle_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 12; i++) begin
         logic [4:0]  o;
         logic [31:0] a, b;
         o = ops[$urandom_range(11, 0)];
         a = $urandom;
         b = ($urandom_range(5, 0) == 0) ? 32'd0 : $urandom;
         issue(o, a, b, model(o, a, b));
      end

      // start held high: ADD accepted only at the first edge after MUL's done falls.
      @(negedge clock);
      start = 1'b1; op = OP_MUL; Ra = 32'hFFFF_FFFD; Rb = 32'd7;
      e = model(OP_MUL, 32'hFFFF_FFFD, 32'd7);
      e.acc_cyc = cyc + 1;
      c0 = e.acc_cyc;
      sb.push_back(e);
      @(negedge clock);
      op = OP_ADD; Ra = 32'd10; Rb = 32'd20;
      e = model(OP_ADD, 32'd10, 32'd20);
      e.acc_cyc = c0 + 35;
      sb.push_back(e);
      drain();
      start = 1'b0;
      repeat (3) @(negedge clock);

      // Reset at edge N+10 of a DIV abandons it; start is ignored in that cycle.
      @(negedge clock);
      start = 1'b1; op = OP_DIV; Ra = 32'd100; Rb = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (8) @(negedge clock);
      chk("mid_div_busy", 64'(busy), 64'd1);
      @(negedge clock);
      reset = 1'b1; start = 1'b1; op = OP_ADD; Ra = 32'd1; Rb = 32'd1;
      @(negedge clock);
      reset = 1'b0; start = 1'b0;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_zhi", 64'(ZHI), 64'd0);
      chk("rst_mid_zlo", 64'(ZLO), 64'd0);
      repeat (40) @(negedge clock);
      chk("post_rst_busy", 64'(busy), 64'd0);

      issue(OP_ADD, 32'h1234_5678, 32'h1111_1111, model(OP_ADD, 32'h1234_5678, 32'h1111_1111));
      repeat (3) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
